// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the memory access controller.
package mem_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_RD_LAT = 1;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-outstanding request/response front end for an external word memory,
// with bounds checking and saturating activity counters.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_readout,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int                LAT_W    = 2;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
    // One extra bit so DEPTH is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    state_e             state_q,     state_d;
    logic               req_ready_q;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_din_q,   mem_din_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q,   rsp_err_d;
    logic [LAT_W-1:0]   lat_q,       lat_d;
    logic [CNT_W-1:0]   wr_cnt_q,    wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q,    rd_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;

    logic handshake;
    logic addr_err;
    logic lat_done;

    assign handshake = req_valid & req_ready_q;
    assign addr_err  = ({1'b0, req_addr} >= DEPTH_L);
    assign lat_done  = (lat_q == LAT_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        lat_d       = lat_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = addr_err;
                    if (addr_err) begin
                        // Out-of-range requests never touch the memory port.
                        state_d   = ST_RESP;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else if (req_we) begin
                        state_d    = ST_WRITE;
                        mem_addr_d = req_addr;
                        mem_din_d  = req_wdata;
                    end else begin
                        state_d    = ST_READ;
                        mem_addr_d = req_addr;
                        lat_d      = '0;
                    end
                end
            end
            ST_WRITE: begin
                state_d  = ST_RESP;
                wr_cnt_d = sat_inc(wr_cnt_q);
            end
            ST_READ: begin
                if (lat_done) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = mem_readout;
                    rd_cnt_d    = sat_inc(rd_cnt_q);
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            lat_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            lat_q       <= lat_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_we      = (state_q == ST_WRITE);
    assign mem_address = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus stall, reset-abort
// and counter-saturation sequences against a small async-read memory model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_din;
    logic [31:0] mem_readout;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W(32),
        .ADDR_W(32),
        .DEPTH (64),
        .RD_LAT(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_address(mem_address),
        .mem_din    (mem_din),
        .mem_readout(mem_readout),
        .wr_cnt     (wr_cnt),
        .rd_cnt     (rd_cnt),
        .err_cnt    (err_cnt)
    );

    // Memory with combinational read: data for the driven address is valid
    // by the end of the single READ cycle (RD_LAT = 1).
    logic [31:0] tb_mem [64];
    assign mem_readout = tb_mem[mem_address[5:0]];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_address[5:0]] <= mem_din;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge on which
    // rsp_valid is first seen (or after the cycle budget runs out).
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int pulses, output logic [31:0] rdata,
                          output logic err, output logic got);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat    = 1;
        pulses = 0;
        got    = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (mem_we) pulses++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_pulses;
        logic [31:0] exp_maddr;
        logic [15:0] exp_wr;
        logic [15:0] exp_rd;
        logic [15:0] exp_er;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          pulses;
        logic [31:0] rdata;
        logic        err;
        logic        got;

        for (int a = 0; a < 64; a++) tb_mem[a] = '0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        //            we    addr          wdata          err   rdata          lat pul maddr   wr  rd  er
        vecs[0] = '{1'b1, 32'd0,        32'd30,        1'b0, 32'd0,         2, 1, 32'd0,  16'd1, 16'd0, 16'd0};
        vecs[1] = '{1'b1, 32'd1,        32'd31,        1'b0, 32'd0,         2, 1, 32'd1,  16'd2, 16'd0, 16'd0};
        vecs[2] = '{1'b0, 32'd0,        32'd0,         1'b0, 32'd30,        2, 0, 32'd0,  16'd2, 16'd1, 16'd0};
        vecs[3] = '{1'b0, 32'd1,        32'd0,         1'b0, 32'd31,        2, 0, 32'd1,  16'd2, 16'd2, 16'd0};
        vecs[4] = '{1'b1, 32'd64,       32'd5,         1'b1, 32'd0,         1, 0, 32'd1,  16'd2, 16'd2, 16'd1};
        vecs[5] = '{1'b1, 32'd63,       32'h0000_DEAD, 1'b0, 32'd0,         2, 1, 32'd63, 16'd3, 16'd2, 16'd1};
        vecs[6] = '{1'b0, 32'd63,       32'd0,         1'b0, 32'h0000_DEAD, 2, 0, 32'd63, 16'd3, 16'd3, 16'd1};
        vecs[7] = '{1'b0, 32'd64,       32'd0,         1'b1, 32'd0,         1, 0, 32'd63, 16'd3, 16'd3, 16'd2};
        vecs[8] = '{1'b0, 32'h8000_0000, 32'd0,        1'b1, 32'd0,         1, 0, 32'd63, 16'd3, 16'd3, 16'd3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_rd_cnt", rd_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, pulses, rdata, err, got);
            check($sformatf("v%0d_rsp_seen", i), got, 1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_mem_we_pulses", i), pulses, vecs[i].exp_pulses);
            check($sformatf("v%0d_rsp_err", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_rsp_rdata", i), rdata, vecs[i].exp_rdata);
            @(negedge clk);
            check($sformatf("v%0d_idle_rsp_valid", i), rsp_valid, 0);
            check($sformatf("v%0d_idle_req_ready", i), req_ready, 1);
            check($sformatf("v%0d_mem_address", i), mem_address, vecs[i].exp_maddr);
            check($sformatf("v%0d_wr_cnt", i), wr_cnt, vecs[i].exp_wr);
            check($sformatf("v%0d_rd_cnt", i), rd_cnt, vecs[i].exp_rd);
            check($sformatf("v%0d_err_cnt", i), err_cnt, vecs[i].exp_er);
        end

        // Back-pressure: response must hold and new requests must be ignored.
        rsp_ready = 1'b0;
        do_txn(1'b0, 32'd0, 32'd0, lat, pulses, rdata, err, got);
        check("stall_rsp_seen", got, 1);
        check("stall_first_rdata", rdata, 32'd30);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd2;
        req_wdata = 32'd77;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_rsp_valid", k), rsp_valid, 1);
            check($sformatf("stall%0d_rsp_rdata", k), rsp_rdata, 32'd30);
            check($sformatf("stall%0d_req_ready", k), req_ready, 0);
            check($sformatf("stall%0d_mem_we", k), mem_we, 0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_release_rsp_valid", rsp_valid, 0);
        check("stall_ignored_write", tb_mem[2], 32'd0);
        check("stall_mem_address", mem_address, 32'd0);
        check("stall_rd_cnt", rd_cnt, 16'd4);
        check("stall_wr_cnt", wr_cnt, 16'd3);

        // Reset while the read is in flight aborts it.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_read_rsp_valid", rsp_valid, 0);
        check("abort_in_read_mem_we", mem_we, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_wr_cnt", wr_cnt, 0);
        check("abort_rd_cnt", rd_cnt, 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_mem_address", mem_address, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_after_rsp_valid", rsp_valid, 0);
        check("abort_after_req_ready", req_ready, 1);
        do_txn(1'b0, 32'd1, 32'd0, lat, pulses, rdata, err, got);
        check("abort_next_rsp_seen", got, 1);
        check("abort_next_latency", lat, 2);
        check("abort_next_rdata", rdata, 32'd31);
        check("abort_next_err", err, 0);
        @(negedge clk);
        check("abort_next_rd_cnt", rd_cnt, 16'd1);

        // Preload the write counter at its ceiling, then confirm it sticks.
        force dut.wr_cnt_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.wr_cnt_q;
        @(negedge clk);
        check("sat_preload", wr_cnt, 16'hFFFF);
        do_txn(1'b1, 32'd3, 32'd9, lat, pulses, rdata, err, got);
        check("sat_rsp_seen", got, 1);
        check("sat_mem_we_pulses", pulses, 1);
        @(negedge clk);
        check("sat_wr_cnt", wr_cnt, 16'hFFFF);
        check("sat_mem_written", tb_mem[3], 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 SHALL have parameter DEPTH, default 64, meaning the number of valid memory words.
REQ-004 SHALL have parameter RD_LAT, default 1, meaning the memory read latency in cycles, from address drive to readout valid; legal range is 1..4.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_we  input  1  1=write, 0=read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  output  1  request address >= DEPTH.
REQ-017 mem_we  output  1  drives the memory write enable.
REQ-018 mem_address  output  ADDR_W  drives the memory address.
REQ-019 mem_din  output  DATA_W  drives the memory write data.
REQ-020 mem_readout  input  DATA_W  memory read data.
REQ-021 wr_cnt, rd_cnt, err_cnt  output  16 each  saturating counts of completed writes, reads and errors.

Function
REQ-022 SHALL implement the FSM states IDLE, WRITE, READ, RESP.
REQ-023 IDLE: req_ready=1 only in this state; a handshake (req_valid & req_ready) SHALL register req_we, req_addr and req_wdata.
REQ-024 Handshake with req_addr >= DEPTH SHALL go directly to RESP with rsp_err=1, without asserting mem_we; err_cnt increments.
REQ-025 Handshake for a valid write SHALL go to WRITE; the registered address and data drive mem_address and mem_din.
REQ-026 WRITE SHALL hold mem_we=1 for exactly one cycle, then enter RESP; wr_cnt increments.
REQ-027 Handshake for a valid read SHALL go to READ; mem_address is driven and mem_we=0.
REQ-028 READ SHALL hold for RD_LAT cycles, counted by an internal latency counter.
REQ-029 On the last READ cycle, mem_readout SHALL be captured into rsp_rdata, then enter RESP; rd_cnt increments.
REQ-030 RESP: rsp_valid=1 and rsp_rdata/rsp_err held stable until rsp_ready=1; on that cycle, return to IDLE.
REQ-031 Request-to-response latency SHALL be: write 2 cycles, read RD_LAT+1 cycles, error 1 cycle; rsp_ready held high gives a minimum issue interval of latency+1 cycles.
REQ-032 mem_we SHALL be 0 in every state except WRITE; mem_address/mem_din retain their last value when not in WRITE or READ.
REQ-033 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-034 req_valid is ignored outside IDLE; no request is buffered.
REQ-035 Address DEPTH-1 SHALL be legal; address DEPTH SHALL be an error.

Reset
REQ-036 On rst=1 at a clock edge: state=IDLE, and all outputs and counters SHALL be 0 except req_ready, which becomes 1 the cycle after rst deasserts.
REQ-037 Reset mid-operation SHALL abort the transaction: no response is issued, and mem_we is 0 from the next edge.
REQ-038 rst has priority over every handshake in the same cycle.

Structure
REQ-039 Package mem_ctrl_pkg SHALL hold the state enum and the default DATA_W/ADDR_W/DEPTH constants.
REQ-040 No sub-module SHALL be used; the memory is instantiated alongside this block, not inside it.

Verification
REQ-041 Write addr 0 data 30, then write addr 1 data 31 -> each write gives one mem_we pulse, rsp_valid 2 cycles after its handshake, wr_cnt=2.
REQ-042 Read addr 0, then read addr 1 after those writes, RD_LAT=1 -> rsp_rdata=30 then 31, rsp_err=0, rd_cnt=2.
REQ-043 Write addr 64 with DEPTH=64 -> no mem_we, rsp_err=1 next cycle, err_cnt=1; addr 63 accepted.
REQ-044 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, req_valid ignored.
REQ-045 Assert rst during READ -> no response, counters 0, then a new request completes normally.
REQ-046 Force wr_cnt to 16'hFFFF and issue a write -> wr_cnt remains 16'hFFFF.
